// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the frequency generator controller.
// Holds the FSM state encoding, the register map and the field widths.
package freq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_CHAN0  = 3'd1;
  localparam logic [2:0] ADDR_CHAN1  = 3'd2;
  localparam logic [2:0] ADDR_CHAN2  = 3'd3;
  localparam logic [2:0] ADDR_CHAN3  = 3'd4;
  localparam logic [2:0] ADDR_CONFIG = 3'd5;
  localparam logic [2:0] ADDR_DWELL  = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  localparam int OSR_W    = 2;
  localparam int LO_DIV_W = 3;
  localparam int F_C_W    = 30;
  localparam int CH_IDX_W = 2;

endpackage

// File: rtl/freq_gen_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
// Shared between the settle interval and the RUN dwell interval.
module freq_gen_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Counter register: load wins, otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/freq_gen_ctrl.sv
// Frequency generator controller: register file, channel-hopping FSM and
// shadowed tuning outputs that only change when a channel is loaded.
module freq_gen_ctrl
  import freq_gen_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_W       = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata,
  output logic                gen_start,
  output logic [F_C_W-1:0]    gen_f_c,
  output logic [OSR_W-1:0]    gen_osr_level,
  output logic [LO_DIV_W-1:0] gen_lo_div_sel,
  output logic                busy,
  output logic                irq_hop
);

  logic                  enable_r;
  logic                  hop_en_r;
  logic [F_C_W-1:0]      chan_r [4];
  logic [OSR_W-1:0]      osr_r;
  logic [LO_DIV_W-1:0]   lo_div_r;
  logic [DWELL_W-1:0]    dwell_r;

  state_t                state_r;
  state_t                next_state_s;
  logic [CH_IDX_W-1:0]   ch_idx_r;
  logic                  dwell_act_r;
  logic                  gen_start_r;
  logic [F_C_W-1:0]      gen_f_c_r;
  logic [OSR_W-1:0]      gen_osr_r;
  logic [LO_DIV_W-1:0]   gen_lo_div_r;
  logic                  busy_r;
  logic                  irq_hop_r;

  logic                  tmr_load_s;
  logic [DWELL_W-1:0]    tmr_val_s;
  logic                  tmr_zero_s;
  logic                  hop_s;
  logic                  unused_wdata_s;

  assign unused_wdata_s = ^cfg_wdata[31:F_C_W];

  // Configuration registers; STATUS is read-only so address 7 is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r  <= 1'b0;
      hop_en_r  <= 1'b0;
      for (int i = 0; i < 4; i++) chan_r[i] <= {F_C_W{1'b0}};
      osr_r     <= {OSR_W{1'b0}};
      lo_div_r  <= {LO_DIV_W{1'b0}};
      dwell_r   <= {DWELL_W{1'b0}};
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_CTRL: begin
          enable_r <= cfg_wdata[0];
          hop_en_r <= cfg_wdata[1];
        end
        ADDR_CHAN0:  chan_r[0] <= cfg_wdata[F_C_W-1:0];
        ADDR_CHAN1:  chan_r[1] <= cfg_wdata[F_C_W-1:0];
        ADDR_CHAN2:  chan_r[2] <= cfg_wdata[F_C_W-1:0];
        ADDR_CHAN3:  chan_r[3] <= cfg_wdata[F_C_W-1:0];
        ADDR_CONFIG: begin
          osr_r    <= cfg_wdata[OSR_W-1:0];
          lo_div_r <= cfg_wdata[OSR_W+LO_DIV_W-1:OSR_W];
        end
        ADDR_DWELL:  dwell_r <= cfg_wdata[DWELL_W-1:0];
        default: ;
      endcase
    end else begin
      enable_r <= enable_r;
    end
  end

  // Combinational read mux; unused bits read as zero
  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      ADDR_CTRL:   cfg_rdata[1:0] = {hop_en_r, enable_r};
      ADDR_CHAN0:  cfg_rdata[F_C_W-1:0] = chan_r[0];
      ADDR_CHAN1:  cfg_rdata[F_C_W-1:0] = chan_r[1];
      ADDR_CHAN2:  cfg_rdata[F_C_W-1:0] = chan_r[2];
      ADDR_CHAN3:  cfg_rdata[F_C_W-1:0] = chan_r[3];
      ADDR_CONFIG: cfg_rdata[OSR_W+LO_DIV_W-1:0] = {lo_div_r, osr_r};
      ADDR_DWELL:  cfg_rdata[DWELL_W-1:0] = dwell_r;
      ADDR_STATUS: cfg_rdata[4:0] = {busy_r, ch_idx_r, state_r};
      default:     cfg_rdata = 32'd0;
    endcase
  end

  freq_gen_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Next-state logic; a low enable overrides everything, including a hop
  always_comb begin
    next_state_s = state_r;
    tmr_load_s   = 1'b0;
    tmr_val_s    = {DWELL_W{1'b0}};
    hop_s        = 1'b0;
    if (!enable_r) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: next_state_s = ST_LOAD;
        ST_LOAD: begin
          next_state_s = ST_SETTLE;
          tmr_load_s   = 1'b1;
          tmr_val_s    = DWELL_W'(SETTLE_CYCLES - 1);
        end
        ST_SETTLE: begin
          if (tmr_zero_s) begin
            next_state_s = ST_RUN;
            tmr_load_s   = 1'b1;
            tmr_val_s    = dwell_r - DWELL_W'(1);
          end else begin
            next_state_s = ST_SETTLE;
          end
        end
        ST_RUN: begin
          if (hop_en_r && dwell_act_r && tmr_zero_s) begin
            next_state_s = ST_LOAD;
            hop_s        = 1'b1;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // State, channel index and registered generator outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ch_idx_r     <= {CH_IDX_W{1'b0}};
      dwell_act_r  <= 1'b0;
      gen_start_r  <= 1'b0;
      gen_f_c_r    <= {F_C_W{1'b0}};
      gen_osr_r    <= {OSR_W{1'b0}};
      gen_lo_div_r <= {LO_DIV_W{1'b0}};
      busy_r       <= 1'b0;
      irq_hop_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      gen_start_r <= (next_state_s == ST_RUN);
      busy_r      <= (next_state_s == ST_LOAD) || (next_state_s == ST_SETTLE);
      irq_hop_r   <= hop_s;
      if (hop_s) begin
        ch_idx_r <= ch_idx_r + CH_IDX_W'(1);
      end else begin
        ch_idx_r <= ch_idx_r;
      end
      // Shadowed settings reach the generator only on a completed LOAD
      if (state_r == ST_LOAD && next_state_s == ST_SETTLE) begin
        gen_f_c_r    <= chan_r[ch_idx_r];
        gen_osr_r    <= osr_r;
        gen_lo_div_r <= lo_div_r;
      end else begin
        gen_f_c_r    <= gen_f_c_r;
      end
      // Dwell validity is sampled at RUN entry so later writes wait their turn
      if (state_r == ST_SETTLE && next_state_s == ST_RUN) begin
        dwell_act_r <= (dwell_r != {DWELL_W{1'b0}});
      end else begin
        dwell_act_r <= dwell_act_r;
      end
    end
  end

  assign gen_start      = gen_start_r;
  assign gen_f_c        = gen_f_c_r;
  assign gen_osr_level  = gen_osr_r;
  assign gen_lo_div_sel = gen_lo_div_r;
  assign busy           = busy_r;
  assign irq_hop        = irq_hop_r;

endmodule

// File: tb/tb_freq_gen_ctrl.sv
// Self-checking bench for freq_gen_ctrl: register table, random register
// traffic, and cycle-accurate hop timing from an arithmetic schedule model.
module tb_freq_gen_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        gen_start;
  logic [29:0] gen_f_c;
  logic [1:0]  gen_osr_level;
  logic [2:0]  gen_lo_div_sel;
  logic        busy;
  logic        irq_hop;

  int total = 0;
  int bad   = 0;
  logic [29:0] chan_m [4];

  freq_gen_ctrl #(.SETTLE_CYCLES(16), .DWELL_W(24)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .gen_start(gen_start),
    .gen_f_c(gen_f_c), .gen_osr_level(gen_osr_level),
    .gen_lo_div_sel(gen_lo_div_sel), .busy(busy), .irq_hop(irq_hop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] reg_mask(input logic [2:0] a);
    case (a)
      3'd0:                reg_mask = 32'h0000_0003;
      3'd1, 3'd2, 3'd3, 3'd4: reg_mask = 32'h3FFF_FFFF;
      3'd5:                reg_mask = 32'h0000_001F;
      3'd6:                reg_mask = 32'h00FF_FFFF;
      default:             reg_mask = 32'h0000_0000;
    endcase
  endfunction

  // Walks n edges after the CTRL write, comparing against the hop schedule:
  // 17 edges of LOAD+SETTLE, then each hop period is dwell RUN + 17 reload.
  task automatic run_model(input string nm, input int n, input bit hop, input int dwell,
                           input int ch0, input logic [29:0] fc_before);
    int p, u, k, r;
    logic gs, iq, bs;
    logic [29:0] fc;
    p = dwell + 17;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t < 18) begin
        gs = 1'b0; iq = 1'b0; bs = 1'b1;
        fc = (t >= 2) ? chan_m[ch0] : fc_before;
      end else if (!hop) begin
        gs = 1'b1; iq = 1'b0; bs = 1'b0; fc = chan_m[ch0];
      end else begin
        u = t - 18; k = u / p; r = u % p;
        gs = (r < dwell); iq = (r == dwell); bs = (r >= dwell);
        fc = chan_m[(ch0 + k + ((r > dwell) ? 1 : 0)) % 4];
      end
      chk($sformatf("%s t=%0d {start,irq,busy,f_c}", nm, t),
          {31'd0, gen_start, irq_hop, busy, gen_f_c}, {31'd0, gs, iq, bs, fc});
    end
  endtask

  initial begin
    vec_t vecs [9];
    logic [31:0] rv;
    logic [31:0] regs_m [8];
    logic [2:0]  a;
    logic [29:0] seen;
    logic        seen_start;
    int          dw;

    reset = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0;

    // Reset with a concurrent write: reset must win
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'h1234_5678;
    do_reset(3);
    cfg_we = 1'b0;
    chk("reset outputs", {gen_start, gen_f_c, gen_osr_level, gen_lo_div_sel, busy, irq_hop}, 64'd0);
    rd(3'd7, rv); chk("reset status", rv, 32'd0);
    rd(3'd1, rv); chk("reset beats write", rv, 32'd0);

    // Register map table
    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
    vecs[1] = '{3'd2, 32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{3'd3, 32'hC000_0001, 32'h0000_0001};
    vecs[3] = '{3'd4, 32'h2AAA_AAAA, 32'h2AAA_AAAA};
    vecs[4] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_001F};
    vecs[5] = '{3'd6, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    vecs[6] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{3'd0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[8] = '{3'd0, 32'h0000_0002, 32'h0000_0002};
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, rv);
      chk($sformatf("regmap vec%0d", i), rv, vecs[i].rexp);
    end

    // Random register traffic against a masked array model
    do_reset(1);
    for (int i = 0; i < 8; i++) regs_m[i] = 32'd0;
    for (int i = 0; i < 24; i++) begin
      a = 3'($urandom_range(1, 7));
      rv = $urandom;
      wr(a, rv);
      regs_m[a] = rv & reg_mask(a);
    end
    for (int i = 1; i < 8; i++) begin
      rd(3'(i), rv);
      chk($sformatf("random reg %0d", i), rv, regs_m[i]);
    end

    // Tune: single channel, no hopping
    do_reset(1);
    chan_m[0] = 30'h02E978D;
    wr(3'd1, 32'h002E978D);
    wr(3'd5, 32'h00000013);
    wr(3'd0, 32'h1);
    run_model("tune", 40, 1'b0, 100, 0, 30'd0);
    chk("tune osr", gen_osr_level, 2'd3);
    chk("tune lo_div", gen_lo_div_sel, 3'd4);

    // Hop through four channels with DWELL=100
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      chan_m[i] = 30'($urandom) ^ 30'(i);
      wr(3'(i + 1), {2'b00, chan_m[i]});
    end
    wr(3'd6, 32'd100);
    wr(3'd0, 32'h3);
    run_model("hop100", 18 + 5 * 117 + 5, 1'b1, 100, 0, 30'd0);

    // Hop with a short random dwell
    do_reset(1);
    dw = $urandom_range(1, 12);
    for (int i = 0; i < 4; i++) begin
      chan_m[i] = 30'($urandom);
      wr(3'(i + 1), {2'b00, chan_m[i]});
    end
    wr(3'd6, 32'(dw));
    wr(3'd0, 32'h3);
    run_model($sformatf("hopd%0d", dw), 18 + 5 * (dw + 17) + 3, 1'b1, dw, 0, 30'd0);

    // Shadow: channel write during RUN waits for the next LOAD
    do_reset(1);
    chan_m[0] = 30'h0ABC_DEF;
    wr(3'd1, {2'b00, chan_m[0]});
    wr(3'd0, 32'h1);
    run_model("shadow", 25, 1'b0, 0, 0, 30'd0);
    wr(3'd1, 32'h1);
    seen = chan_m[0];
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (gen_f_c != chan_m[0]) seen = gen_f_c;
    end
    chk("shadow hold", seen, chan_m[0]);
    wr(3'd0, 32'h0);
    wr(3'd0, 32'h1);
    tick(); tick();
    chk("shadow reload", gen_f_c, 30'h1);

    // Race: disable lands with dwell expiry after one hop (ch_idx=1)
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      chan_m[i] = 30'h100 * 30'(i + 1);
      wr(3'(i + 1), {2'b00, chan_m[i]});
    end
    wr(3'd6, 32'd10);
    wr(3'd0, 32'h3);
    run_model("race", 53, 1'b1, 10, 0, 30'd0);
    wr(3'd0, 32'h0);
    chk("race still run", gen_start, 1'b1);
    tick();
    chk("race start low", gen_start, 1'b0);
    chk("race no irq", irq_hop, 1'b0);
    rd(3'd7, rv); chk("race status", rv, 32'h4);
    tick();
    chk("race no late irq", irq_hop, 1'b0);
    wr(3'd0, 32'h3);
    tick(); tick();
    chk("resume channel", gen_f_c, chan_m[1]);

    // Mid-operation reset during SETTLE
    do_reset(1);
    chan_m[0] = 30'h155;
    wr(3'd1, 32'h155);
    wr(3'd0, 32'h1);
    repeat (7) tick();
    chk("settle busy", busy, 1'b1);
    do_reset(1);
    chk("midreset outputs", {gen_start, gen_f_c, gen_osr_level, gen_lo_div_sel, busy, irq_hop}, 64'd0);
    seen_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gen_start) seen_start = 1'b1;
    end
    chk("midreset no start", seen_start, 1'b0);
    rd(3'd7, rv); chk("midreset status", rv, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
